// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port synchronous data memory.
// Each granted op runs IDLE -> ACCESS -> RESP (or IDLE -> RESP when out of range).
module data_mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic              p0_err,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic              p1_err,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_read_data
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic              sel;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] resp_data;
   logic              resp;

   // Memory read data is only valid during RESP, so it is forwarded then and held afterwards.
   assign resp_data = err_q ? '0 : mem_read_data;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      err_d    = err_q;
      last_d   = last_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      sel      = 1'b0;
      sel_addr = '0;
      case (state_q)
         StIdle: begin
            if (p0_req || p1_req) begin
               sel      = (p0_req && p1_req) ? ~last_q : p1_req;
               sel_addr = sel ? p1_addr : p0_addr;
               owner_d  = sel;
               we_d     = sel ? p1_we : p0_we;
               addr_d   = sel_addr;
               wdata_d  = sel ? p1_wdata : p0_wdata;
               // Full-width compare: high address bits must never alias into range.
               err_d    = !(sel_addr < ADDR_W'(DEPTH));
               state_d  = err_d ? StResp : StAccess;
            end
         end
         StAccess: state_d = StResp;
         StResp: begin
            last_d  = owner_q;
            state_d = StIdle;
            if (owner_q) rdata1_d = resp_data;
            else         rdata0_d = resp_data;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         last_q   <= 1'b1;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         err_q    <= err_d;
         last_q   <= last_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign resp           = (state_q == StResp);
   assign busy           = (state_q != StIdle);
   assign mem_address    = addr_q;
   assign mem_write_data = wdata_q;
   assign mem_read       = (state_q == StAccess) && !we_q;
   assign mem_write      = (state_q == StAccess) && we_q;
   assign p0_ack         = resp && !owner_q;
   assign p1_ack         = resp && owner_q;
   assign p0_err         = p0_ack && err_q;
   assign p1_err         = p1_ack && err_q;
   assign p0_rdata       = p0_ack ? resp_data : rdata0_q;
   assign p1_rdata       = p1_ack ? resp_data : rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed steps plus randomized dual-request traffic
// checked against an array-based reference of memory contents and round-robin order.
module tb_data_mem_arbiter;
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
   logic [AW-1:0] p0_addr = '0, p1_addr = '0;
   logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
   logic          p0_ack, p0_err, p1_ack, p1_err, busy, mem_read, mem_write;
   logic [DW-1:0] p0_rdata, p1_rdata, mem_write_data;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_read_data = '0;

   logic [DW-1:0] mem     [0:7] = '{0, 28, 56, 84, 112, 0, 168, 196};
   logic [DW-1:0] ref_mem [0:7] = '{0, 28, 56, 84, 112, 0, 168, 196};
   logic [AW-1:0] last_wr_addr = '0;
   int            rd_cnt = 0, wr_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
   int            errors = 0, checks = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
      .busy(busy), .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
   );

   // Synchronous read-before-write memory
   always @(posedge clk) begin
      if (mem_read || mem_write) begin
         mem_read_data <= mem[mem_address[2:0]];
         if (mem_write) begin
            mem[mem_address[2:0]] <= mem_write_data;
            last_wr_addr          <= mem_address;
         end
      end
   end

   always @(negedge clk) begin
      if (mem_read)  rd_cnt   <= rd_cnt + 1;
      if (mem_write) wr_cnt   <= wr_cnt + 1;
      if (p0_ack)    ack0_cnt <= ack0_cnt + 1;
      if (p1_ack)    ack1_cnt <= ack1_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic req, input logic we, input logic [31:0] a,
                           input logic [31:0] d);
      if (p == 0) begin
         p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
      end else begin
         p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
      end
   endtask

   // Reference: an op either faults (out of range) or reads the current word, then maybe writes.
   task automatic model_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] er, output logic ee);
      if (a >= DEPTH) begin
         er = '0; ee = 1'b1;
      end else begin
         er = ref_mem[a[2:0]]; ee = 1'b0;
         if (we) ref_mem[a[2:0]] = d;
      end
   endtask

   function automatic logic ack_of(input int p);
      return (p == 0) ? p0_ack : p1_ack;
   endfunction
   function automatic logic err_of(input int p);
      return (p == 0) ? p0_err : p1_err;
   endfunction
   function automatic logic [31:0] rdata_of(input int p);
      return (p == 0) ? p0_rdata : p1_rdata;
   endfunction

   // Called at a negedge while idle; returns at the negedge after the ack cycle.
   task automatic do_op(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input string tag);
      int          n;
      logic [31:0] er;
      logic        ee;
      set_port(p, 1'b1, we, a, d);
      n = 0;
      do begin @(negedge clk); n++; end while (!ack_of(p) && n < 20);
      model_op(we, a, d, er, ee);
      chk({tag, "_latency"}, n, ee ? 1 : 2);
      chk({tag, "_rdata"}, rdata_of(p), er);
      chk({tag, "_err"}, {31'b0, err_of(p)}, {31'b0, ee});
      chk({tag, "_other_ack"}, {31'b0, ack_of(1 - p)}, 0);
      set_port(p, 1'b0, we, a, d);
      @(negedge clk);
      chk({tag, "_idle"}, {31'b0, busy}, 0);
      chk({tag, "_held"}, rdata_of(p), er);
   endtask

   initial begin
      int          n, a0, a1, s0, w0, cyc, last, nack, expp, p;
      logic [31:0] er;
      logic        ee;
      logic        cw [2];
      logic [31:0] ca [2];
      logic [31:0] cd [2];

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ack_err", {26'b0, p0_ack, p0_err, p1_ack, p1_err, busy, mem_read}, 0);
      chk("rst_mem_write", {31'b0, mem_write}, 0);
      chk("rst_rdata", p0_rdata | p1_rdata, 0);
      chk("rst_mem_address", mem_address, 0);
      reset = 1'b0;
      @(negedge clk);

      // 1: p0 read of addr 1
      do_op(0, 1'b0, 32'd1, 32'd0, "t1");
      chk("t1_p1_quiet", {30'b0, p1_ack, p1_err}, 0);
      chk("t1_p1_rdata", p1_rdata, 0);

      // 2: p1 write then p0 read-back
      w0 = wr_cnt;
      do_op(1, 1'b1, 32'd5, 32'h0000_00A5, "t2w");
      @(negedge clk);
      chk("t2_write_pulses", wr_cnt - w0, 1);
      chk("t2_write_addr", last_wr_addr, 5);
      do_op(0, 1'b0, 32'd5, 32'd0, "t2r");

      // 6: p0 keeps req one cycle past ack, giving a second op
      a0 = ack0_cnt; a1 = ack1_cnt;
      set_port(0, 1'b1, 1'b0, 32'd2, 32'd0);
      for (int k = 0; k < 2; k++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!p0_ack && n < 20);
         model_op(1'b0, 32'd2, 32'd0, er, ee);
         chk("t6_latency", n, 2);
         chk("t6_rdata", p0_rdata, er);
         if (k == 0) begin
            @(negedge clk);
            chk("t6_idle_between", {31'b0, busy}, 0);
         end
      end
      set_port(0, 1'b0, 1'b0, 32'd2, 32'd0);
      repeat (2) @(negedge clk);
      chk("t6_p0_acks", ack0_cnt - a0, 2);
      chk("t6_p1_acks", ack1_cnt - a1, 0);

      // 4: out-of-range read and write never reach memory
      s0 = rd_cnt + wr_cnt;
      do_op(0, 1'b0, 32'd8, 32'd0, "t4r");
      do_op(0, 1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, "t4w");
      @(negedge clk);
      chk("t4_no_strobes", rd_cnt + wr_cnt - s0, 0);
      for (int i = 0; i < 8; i++) chk($sformatf("t4_mem%0d", i), mem[i], ref_mem[i]);

      // 5: reset during ACCESS of a p1 write
      a1 = ack1_cnt;
      set_port(1, 1'b1, 1'b1, 32'd3, 32'h1234_5678);
      @(negedge clk);
      chk("t5_in_access", {31'b0, mem_write}, 1);
      #2 reset = 1'b1;
      #1;
      chk("t5_strobes_drop", {30'b0, mem_write, mem_read}, 0);
      chk("t5_busy_drop", {31'b0, busy}, 0);
      @(negedge clk);
      reset = 1'b0;
      set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      chk("t5_no_ack", ack1_cnt - a1, 0);
      chk("t5_mem_unchanged", mem[3], ref_mem[3]);
      set_port(0, 1'b1, 1'b0, 32'd2, 32'd0);
      set_port(1, 1'b1, 1'b0, 32'd6, 32'd0);
      n = 0;
      do begin @(negedge clk); n++; end while (!(p0_ack || p1_ack) && n < 20);
      chk("t5_p0_wins", {30'b0, p0_ack, p1_ack}, 2);
      model_op(1'b0, 32'd2, 32'd0, er, ee);
      chk("t5_p0_rdata", p0_rdata, er);
      set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      n = 0;
      do begin @(negedge clk); n++; end while (!p1_ack && n < 20);
      model_op(1'b0, 32'd6, 32'd0, er, ee);
      chk("t5_p1_rdata", p1_rdata, er);
      set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);

      // 3: continuous random dual requests from reset alternate 0,1,0,1 every 3 cycles
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int q = 0; q < 2; q++) begin
         cw[q] = 1'($urandom_range(0, 1)); ca[q] = $urandom_range(0, 7); cd[q] = $urandom;
         set_port(q, 1'b1, cw[q], ca[q], cd[q]);
      end
      cyc = 0; last = -1; nack = 0; expp = 0;
      while (nack < 8 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (p0_ack || p1_ack) begin
            p = p1_ack ? 1 : 0;
            chk("t3_single_ack", {31'b0, p0_ack && p1_ack}, 0);
            chk("t3_grant_order", p, expp);
            chk("t3_interval", cyc - last, 3);
            model_op(cw[p], ca[p], cd[p], er, ee);
            chk("t3_rdata", rdata_of(p), er);
            nack++; expp = 1 - expp; last = cyc;
            cw[p] = 1'($urandom_range(0, 1)); ca[p] = $urandom_range(0, 7); cd[p] = $urandom;
            set_port(p, nack < 8, cw[p], ca[p], cd[p]);
         end
      end
      set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("t3_ack_count", nack, 8);
      @(negedge clk);
      for (int i = 0; i < 8; i++) chk($sformatf("t3_mem%0d", i), mem[i], ref_mem[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
